counter_match_irq: RTL and testbench
====================================

Name: counter_match_irq

Overview:
- Sits directly downstream of the user-area free-running counter. Consumes its `count` bus and raises the user IRQ lines.
- Provides two compare channels and one input-capture channel.
- Configured and observed by the management SoC through the same single-beat valid/ready register handshake the counter uses.
- Drives `irq[2:0]` of the user project.

Parameters:
- BITS, 32, width of the consumed count; 1..32; zero-extended to 32 on reads.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- valid  input  1  register access request (wishbone cyc&stb)
- addr  input  3  word index (byte address [4:2])
- wstrb  input  4  byte write enables; all zero = read
- wdata  input  32  write data
- ready  output  1  one-cycle access acknowledge
- rdata  output  32  registered read data
- count  input  BITS  live counter value
- cap_in  input  1  asynchronous capture trigger (from io_in)
- irq  output  3  [0]=compare0, [1]=compare1, [2]=capture; level

Behaviour:
- Reset values: ready=0, rdata=0, irq=0; CMP0, CMP1, CTRL, STATUS, CAPTURE=0; sync flops=0; `armed`=0.
- Register map (word index):
  - 0 CMP0 RW[BITS-1:0]
  - 1 CMP1 RW
  - 2 CTRL RW:
    - bit0 en0
    - bit1 en1
    - bit2 cap_en
    - bit3 cap_fall (0 = rising, 1 = falling)
    - bits[10:8] irq mask
    - other bits read 0, writes ignored
  - 3 STATUS bits[2:0], sticky, write-1-to-clear per bit; writing 0 has no effect.
  - 4 CAPTURE RO.
  - 5..7 read 0; writes ignored.
- Handshake:
  - Access is accepted on a cycle with valid=1 and ready=0.
  - Next cycle: ready=1 for exactly one cycle; rdata = register value before any write in that access.
  - Byte lanes are written per wstrb in the accept cycle.
  - valid held high yields ready toggling 1,0,1,… (one access per two cycles).
  - rdata holds its value between accesses.
- Compare:
  - `armed` is set to 1 one cycle after reset deasserts.
  - prev_count is registered every cycle.
  - Match k when armed & en_k & count==CMPk & (count!=prev_count | CMPk write accepted previous cycle).
  - A stalled count therefore does not re-fire.
  - On match, STATUS[k] is set at the next clock edge.
- Capture:
  - cap_in passes through a 2-flop synchroniser (s1, s2) plus delay flop s3.
  - Rising edge = s2&~s3; falling edge = ~s2&s3, selected by cap_fall.
  - When cap_en and the selected edge occur on a clock edge: CAPTURE<=count, STATUS[2]<=1.
  - A new edge overwrites CAPTURE even if STATUS[2] is already set.
  - cap_in high for <2 cycles may be missed; no guarantee.
- irq = STATUS[2:0] & CTRL[10:8], combinational from registers.
  - irq rises one cycle after the matching count value is presented.
- Simultaneous events:
  - A set and a W1C clear of the same STATUS bit in one cycle: set wins, bit stays 1.
  - A CMPk write in the same cycle as a match against the old value: match counts, new value takes effect next cycle.
- Clearing en_k does not clear STATUS[k].
- Reset mid-access: ready drops to 0 the next cycle and the access is lost; mid-operation reset clears all state as above.
- Count wrap (all ones to 0) is a normal value change; CMP=0 matches after wrap.

Test Plan:
- Reset, read idx 0..7 -> each access: ready high exactly one cycle after accept, rdata=0, irq=0.
- CMP0=100, CTRL=0x101, count ramps 95..105 -> STATUS[0]=1 and irq[0]=1 from the cycle after count=100; irq stays high until W1C 0x1 to STATUS, then 0.
- count stalled at 50 for 10 cycles with CMP1=50, en1: fire once, clear STATUS, stall continues -> no re-set; write CMP1=50 again -> set once more.
- cap_en=1, rising, cap_in 0->1 before edge N -> CAPTURE=count at edge N+2, STATUS[2]=1; with cap_fall=1 the rising edge does not capture, the later fall does.
- W1C of STATUS[0] on the same cycle as a new CMP0 match -> STATUS[0] remains 1; write wstrb=4'b0001 of 0xFFFFFFAA to CMP0 (previously 0x12345678) -> reads 0x123456AA.
- BITS=8 build: count wraps 255->0 with CMP0=0 -> match fires; reads of CAPTURE are zero-extended (upper 24 bits 0).

Source files
------------

// File: rtl/counter_match_irq.sv
// Two compare channels and one input-capture channel on the free-running user counter,
// with a single-beat valid/ready register port and level interrupts on irq_o[2:0].
module counter_match_irq #(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      addr_i,
  input  logic [3:0]      wstrb_i,
  input  logic [31:0]     wdata_i,
  output logic            ready_o,
  output logic [31:0]     rdata_o,
  input  logic [BITS-1:0] count_i,
  input  logic            cap_in_i,
  output logic [2:0]      irq_o
);

  localparam logic [2:0] AddrCmp0    = 3'd0;
  localparam logic [2:0] AddrCmp1    = 3'd1;
  localparam logic [2:0] AddrCtrl    = 3'd2;
  localparam logic [2:0] AddrStatus  = 3'd3;
  localparam logic [2:0] AddrCapture = 3'd4;

  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [BITS-1:0] cmp0_q, cmp0_d, cmp1_q, cmp1_d;
  logic [3:0]      ctrl_q, ctrl_d;  // {cap_fall, cap_en, en1, en0}
  logic [2:0]      mask_q, mask_d;
  logic [2:0]      status_q, status_d;
  logic [BITS-1:0] capture_q, capture_d;
  logic [BITS-1:0] prev_q;
  logic            armed_q;
  logic [1:0]      cmp_wr_q, cmp_wr_d;
  logic            s1_q, s2_q, s3_q;

  logic        accept, wr;
  logic [31:0] wmask, rd_val;
  logic [2:0]  set, clr;
  logic        cap_edge;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  always_comb begin
    accept = valid_i & ~ready_q;
    wr     = accept & (|wstrb_i);
    wmask  = {{8{wstrb_i[3]}}, {8{wstrb_i[2]}}, {8{wstrb_i[1]}}, {8{wstrb_i[0]}}};

    case (addr_i)
      AddrCmp0:    rd_val = 32'(cmp0_q);
      AddrCmp1:    rd_val = 32'(cmp1_q);
      AddrCtrl:    rd_val = {21'b0, mask_q, 4'b0, ctrl_q};
      AddrStatus:  rd_val = {29'b0, status_q};
      AddrCapture: rd_val = 32'(capture_q);
      default:     rd_val = 32'b0;
    endcase

    ready_d = accept;
    rdata_d = accept ? rd_val : rdata_q;

    cmp0_d   = cmp0_q;
    cmp1_d   = cmp1_q;
    ctrl_d   = ctrl_q;
    mask_d   = mask_q;
    cmp_wr_d = 2'b00;
    clr      = 3'b000;
    if (wr) begin
      case (addr_i)
        AddrCmp0: begin
          cmp0_d      = BITS'(merge(32'(cmp0_q), wdata_i, wmask));
          cmp_wr_d[0] = 1'b1;
        end
        AddrCmp1: begin
          cmp1_d      = BITS'(merge(32'(cmp1_q), wdata_i, wmask));
          cmp_wr_d[1] = 1'b1;
        end
        AddrCtrl: begin
          if (wstrb_i[0]) ctrl_d = wdata_i[3:0];
          if (wstrb_i[1]) mask_d = wdata_i[10:8];
        end
        AddrStatus: begin
          if (wstrb_i[0]) clr = wdata_i[2:0];
        end
        default: ;
      endcase
    end

    // A freshly written CMP may match a stalled count once; otherwise only a count change fires.
    set[0] = armed_q & ctrl_q[0] & (count_i == cmp0_q) & ((count_i != prev_q) | cmp_wr_q[0]);
    set[1] = armed_q & ctrl_q[1] & (count_i == cmp1_q) & ((count_i != prev_q) | cmp_wr_q[1]);

    cap_edge  = ctrl_q[3] ? (~s2_q & s3_q) : (s2_q & ~s3_q);
    set[2]    = ctrl_q[2] & cap_edge;
    capture_d = set[2] ? count_i : capture_q;

    // Set takes priority over a same-cycle write-1-to-clear.
    status_d = (status_q & ~clr) | set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= 32'b0;
      cmp0_q    <= '0;
      cmp1_q    <= '0;
      ctrl_q    <= 4'b0;
      mask_q    <= 3'b0;
      status_q  <= 3'b0;
      capture_q <= '0;
      prev_q    <= '0;
      armed_q   <= 1'b0;
      cmp_wr_q  <= 2'b00;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      cmp0_q    <= cmp0_d;
      cmp1_q    <= cmp1_d;
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      status_q  <= status_d;
      capture_q <= capture_d;
      prev_q    <= count_i;
      armed_q   <= 1'b1;
      cmp_wr_q  <= cmp_wr_d;
      s1_q      <= cap_in_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign irq_o   = status_q & mask_q;

endmodule

// File: tb/tb_counter_match_irq.sv
// Bench for counter_match_irq: a cycle model checked every cycle on a 32-bit instance,
// directed vectors with literal expectations, and an 8-bit instance for wrap/zero-extension.
module tb_counter_match_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [2:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] count;
  logic        cap_in;
  logic [2:0]  irq;

  logic        v8;
  logic [2:0]  a8;
  logic [3:0]  ws8;
  logic [31:0] wd8;
  logic        rdy8;
  logic [31:0] rd8;
  logic [7:0]  cnt8;
  logic        cap8;
  logic [2:0]  irq8;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  counter_match_irq #(.BITS(32)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid),
    .addr_i   (addr),
    .wstrb_i  (wstrb),
    .wdata_i  (wdata),
    .ready_o  (ready),
    .rdata_o  (rdata),
    .count_i  (count),
    .cap_in_i (cap_in),
    .irq_o    (irq)
  );

  counter_match_irq #(.BITS(8)) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (v8),
    .addr_i   (a8),
    .wstrb_i  (ws8),
    .wdata_i  (wd8),
    .ready_o  (rdy8),
    .rdata_o  (rd8),
    .count_i  (cnt8),
    .cap_in_i (cap8),
    .irq_o    (irq8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the 32-bit instance ----------------
  logic        m_init = 1'b0;
  logic        m_ready, m_armed;
  logic [31:0] m_rdata, m_ctrl, m_cap, m_prev;
  logic [31:0] m_cmp [2];
  logic [2:0]  m_status, m_hist, m_s, m_clr;
  logic [1:0]  m_fresh;
  logic        m_acc, m_wr;

  function automatic logic [31:0] m_merge(input logic [31:0] old);
    logic [31:0] wm;
    for (int b = 0; b < 4; b++) wm[8*b +: 8] = {8{wstrb[b]}};
    return (old & ~wm) | (wdata & wm);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_cmp[0];
      3'd1:    return m_cmp[1];
      3'd2:    return m_ctrl;
      3'd3:    return {29'b0, m_status};
      3'd4:    return m_cap;
      default: return 32'b0;
    endcase
  endfunction

  always_comb begin
    m_acc = valid && !m_ready;
    m_wr  = m_acc && (wstrb != 4'b0);
    m_s   = 3'b0;
    for (int k = 0; k < 2; k++)
      if (m_armed && m_ctrl[k] && count == m_cmp[k] && (count != m_prev || m_fresh[k]))
        m_s[k] = 1'b1;
    // m_hist[1] is the value two samples old, m_hist[2] three samples old
    if (m_ctrl[2] && (m_ctrl[3] ? (!m_hist[1] && m_hist[2]) : (m_hist[1] && !m_hist[2])))
      m_s[2] = 1'b1;
    m_clr = (m_wr && addr == 3'd3 && wstrb[0]) ? wdata[2:0] : 3'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_init   <= 1'b1;
      m_ready  <= 1'b0;
      m_armed  <= 1'b0;
      m_rdata  <= 32'b0;
      m_ctrl   <= 32'b0;
      m_cap    <= 32'b0;
      m_prev   <= 32'b0;
      m_cmp[0] <= 32'b0;
      m_cmp[1] <= 32'b0;
      m_status <= 3'b0;
      m_hist   <= 3'b0;
      m_fresh  <= 2'b0;
    end else if (m_init) begin
      m_ready <= m_acc;
      if (m_acc) m_rdata <= m_read(addr);
      if (m_wr && addr == 3'd0) m_cmp[0] <= m_merge(m_cmp[0]);
      if (m_wr && addr == 3'd1) m_cmp[1] <= m_merge(m_cmp[1]);
      if (m_wr && addr == 3'd2) m_ctrl <= m_merge(m_ctrl) & 32'h0000_070F;
      m_fresh  <= {m_wr && addr == 3'd1, m_wr && addr == 3'd0};
      m_status <= (m_status & ~m_clr) | m_s;
      if (m_s[2]) m_cap <= count;
      m_prev  <= count;
      m_armed <= 1'b1;
      m_hist  <= {m_hist[1:0], cap_in};
    end
  end

  always @(negedge clk) begin
    if (m_init && !reset) begin
      check("mdl_ready", {31'b0, ready}, {31'b0, m_ready});
      check("mdl_rdata", rdata, m_rdata);
      check("mdl_irq", {29'b0, irq}, {29'b0, m_status & m_ctrl[10:8]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit b8, input logic [2:0] a, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] rd);
    if (b8) begin
      v8 = 1'b1; a8 = a; ws8 = ws; wd8 = wd;
    end else begin
      valid = 1'b1; addr = a; wstrb = ws; wdata = wd;
    end
    tick();
    if (b8) begin
      check("ack8", {31'b0, rdy8}, 32'd1);
      rd = rd8;
      v8 = 1'b0;
    end else begin
      check("ack", {31'b0, ready}, 32'd1);
      rd = rdata;
      valid = 1'b0;
    end
    tick();
    check("ack_drop", {31'b0, b8 ? rdy8 : ready}, 32'd0);
  endtask

  task automatic wr(input bit b8, input logic [2:0] a, input logic [31:0] d);
    logic [31:0] unused;
    bus(b8, a, 4'hF, d, unused);
  endtask

  task automatic rd_chk(input bit b8, input string name, input logic [2:0] a,
                        input logic [31:0] exp);
    logic [31:0] got;
    bus(b8, a, 4'h0, 32'h0, got);
    check(name, got, exp);
  endtask

  initial begin
    logic [31:0] tmp;
    reset = 1'b1; valid = 1'b0; addr = 3'd0; wstrb = 4'h0; wdata = 32'h0;
    count = 32'd0; cap_in = 1'b0;
    v8 = 1'b0; a8 = 3'd0; ws8 = 4'h0; wd8 = 32'h0; cnt8 = 8'd0; cap8 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {29'b0, irq}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      rd_chk(1'b0, "rst_reg", 3'(i), 32'd0);
      check("rst_reg_irq", {29'b0, irq}, 32'd0);
    end

    // compare 0 on a ramp
    wr(1'b0, 3'd0, 32'd100);
    wr(1'b0, 3'd2, 32'h101);
    for (int c = 95; c <= 105; c++) begin
      count = 32'(c);
      tick();
      check("ramp_irq0", {31'b0, irq[0]}, {31'b0, c >= 100});
    end
    rd_chk(1'b0, "ramp_status", 3'd3, 32'd1);
    wr(1'b0, 3'd3, 32'd1);
    check("w1c_irq0", {29'b0, irq}, 32'd0);

    // stalled count on compare 1
    count = 32'd49;
    wr(1'b0, 3'd1, 32'd50);
    wr(1'b0, 3'd2, 32'h202);
    count = 32'd50;
    repeat (10) tick();
    rd_chk(1'b0, "stall_fire", 3'd3, 32'd2);
    check("stall_irq", {29'b0, irq}, 32'd2);
    wr(1'b0, 3'd3, 32'd2);
    repeat (5) tick();
    rd_chk(1'b0, "stall_norefire", 3'd3, 32'd0);
    wr(1'b0, 3'd1, 32'd50);
    rd_chk(1'b0, "rewrite_fire", 3'd3, 32'd2);
    wr(1'b0, 3'd3, 32'd7);

    // capture, rising then falling
    wr(1'b0, 3'd2, 32'h404);
    for (int i = 0; i < 6; i++) begin
      count = 32'd2000 + 32'(i);
      if (i == 0) cap_in = 1'b1;
      tick();
    end
    rd_chk(1'b0, "cap_rise", 3'd4, 32'd2002);
    rd_chk(1'b0, "cap_rise_st", 3'd3, 32'd4);
    check("cap_irq", {29'b0, irq}, 32'd4);
    cap_in = 1'b0;
    for (int i = 0; i < 5; i++) begin count = 32'd2100 + 32'(i); tick(); end
    rd_chk(1'b0, "cap_fall_ignored", 3'd4, 32'd2002);
    wr(1'b0, 3'd3, 32'd4);
    wr(1'b0, 3'd2, 32'h40C);
    cap_in = 1'b1;
    for (int i = 0; i < 5; i++) begin count = 32'd2200 + 32'(i); tick(); end
    rd_chk(1'b0, "cap_rise_ignored", 3'd3, 32'd0);
    cap_in = 1'b0;
    for (int i = 0; i < 5; i++) begin count = 32'd2300 + 32'(i); tick(); end
    rd_chk(1'b0, "cap_fall", 3'd4, 32'd2302);
    wr(1'b0, 3'd3, 32'd7);
    wr(1'b0, 3'd2, 32'd0);

    // byte lanes and simultaneous events
    wr(1'b0, 3'd0, 32'h1234_5678);
    bus(1'b0, 3'd0, 4'b0001, 32'hFFFF_FFAA, tmp);
    rd_chk(1'b0, "byte_lane", 3'd0, 32'h1234_56AA);
    wr(1'b0, 3'd0, 32'd300);
    wr(1'b0, 3'd2, 32'h101);
    count = 32'd299; tick();
    count = 32'd300; tick();
    count = 32'd301; tick();
    check("pre_w1c_irq", {29'b0, irq}, 32'd1);
    count = 32'd300;
    wr(1'b0, 3'd3, 32'd1);
    rd_chk(1'b0, "set_beats_clr", 3'd3, 32'd1);
    wr(1'b0, 3'd3, 32'd1);
    rd_chk(1'b0, "clr_on_stall", 3'd3, 32'd0);
    count = 32'd301; tick();
    count = 32'd300;
    wr(1'b0, 3'd0, 32'd500);
    rd_chk(1'b0, "old_cmp_match", 3'd3, 32'd1);
    rd_chk(1'b0, "new_cmp", 3'd0, 32'd500);

    // reset in the middle of an access
    valid = 1'b1; addr = 3'd2; wstrb = 4'h0;
    tick();
    reset = 1'b1; valid = 1'b0;
    tick();
    check("midrst_ready", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    rd_chk(1'b0, "midrst_ctrl", 3'd2, 32'd0);
    rd_chk(1'b0, "midrst_status", 3'd3, 32'd0);

    // 8-bit instance: wrap match and zero-extension
    cnt8 = 8'd253;
    wr(1'b1, 3'd0, 32'hFFFF_FF00);
    wr(1'b1, 3'd2, 32'h105);
    for (int i = 0; i < 4; i++) begin
      cnt8 = 8'(253 + i);
      tick();
      check("wrap_irq0", {31'b0, irq8[0]}, {31'b0, i == 3});
    end
    for (int i = 0; i < 5; i++) begin
      cnt8 = 8'hC0 + 8'(i);
      if (i == 0) cap8 = 1'b1;
      tick();
    end
    rd_chk(1'b1, "cap8_zext", 3'd4, 32'h0000_00C2);
    rd_chk(1'b1, "status8", 3'd3, 32'd5);
    check("irq8_masked", {29'b0, irq8}, 32'd1);
    wr(1'b1, 3'd1, 32'hFFFF_FFAA);
    rd_chk(1'b1, "cmp8_zext", 3'd1, 32'h0000_00AA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
